// File: rtl/acc_pkg.sv
// acc_pkg: loop-controller state and ordinary-command encodings for acc_bank.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

package acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } loop_state_e;

   typedef enum logic [2:0] {
      CMD_NONE = 3'd0,
      CMD_CLR  = 3'd1,
      CMD_LOAD = 3'd2,
      CMD_ALU  = 3'd3,
      CMD_INC  = 3'd4,
      CMD_DEC  = 3'd5
   } cmd_e;

   // Exactly one ordinary command wins per cycle; the rest are dropped.
   function automatic cmd_e decode_cmd(input logic clr, input logic wr, input logic alu,
                                       input logic inc, input logic dec);
      if (clr)      return CMD_CLR;
      else if (wr)  return CMD_LOAD;
      else if (alu) return CMD_ALU;
      else if (inc) return CMD_INC;
      else if (dec) return CMD_DEC;
      else          return CMD_NONE;
   endfunction

endpackage

`default_nettype wire

// File: rtl/acc_bank_if.sv
// acc_bank_if: command, loop-control and read-port bundle of the accumulator bank.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

interface acc_bank_if #(
   parameter int WIDTH = 16,
   parameter int NREGS = 4
);
   localparam int SEL_W = $clog2(NREGS);

   logic [SEL_W-1:0] sel;
   logic             clr_en;
   logic             write_en;
   logic             alu_to_ac;
   logic             inc_en;
   logic             dec_en;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] alu_out;
   logic             loop_start;
   logic             loop_abort;
   logic [SEL_W-1:0] rd_sel;
   logic [WIDTH-1:0] data_out;
   logic             zero;
   logic             carry;
   logic             loop_busy;
   logic             loop_done;

   modport master (
      output sel, clr_en, write_en, alu_to_ac, inc_en, dec_en, data_in, alu_out,
             loop_start, loop_abort, rd_sel,
      input  data_out, zero, carry, loop_busy, loop_done
   );

   modport slave (
      input  sel, clr_en, write_en, alu_to_ac, inc_en, dec_en, data_in, alu_out,
             loop_start, loop_abort, rd_sel,
      output data_out, zero, carry, loop_busy, loop_done
   );

endinterface

`default_nettype wire

// File: rtl/acc_loop_ctrl.sv
// acc_loop_ctrl: hardware loop FSM that locks one entry and counts it down to zero.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module acc_loop_ctrl
   import acc_pkg::*;
#(
   parameter int SEL_W = 2
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             start_i,
   input  wire logic             abort_i,
   input  wire logic [SEL_W-1:0] sel_i,
   input  wire logic             cnt_zero_i,
   input  wire logic             last_i,
   output logic                  start_ack_o,
   output logic                  dec_o,
   output logic [SEL_W-1:0]      lock_sel_o,
   output logic                  lock_match_o,
   output logic                  busy_o,
   output logic                  done_o
);

   loop_state_e      state_q, state_d;
   logic [SEL_W-1:0] lock_q, lock_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lock_d      = lock_q;
      start_ack_o = 1'b0;
      dec_o       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               start_ack_o = 1'b1;
               lock_d      = sel_i;
               state_d     = cnt_zero_i ? DONE : COUNT;
            end
         end
         COUNT: begin
            // Abort freezes the entry: no decrement on the aborting edge.
            if (abort_i) begin
               state_d = IDLE;
            end else begin
               dec_o = 1'b1;
               if (last_i) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign lock_sel_o   = lock_q;
   assign lock_match_o = (state_q == COUNT) && (sel_i == lock_q);
   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == DONE);

endmodule

`default_nettype wire

// File: rtl/acc_bank.sv
// acc_bank: bank of NREGS accumulators with priority commands, carry flag and a loop counter.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module acc_bank
   import acc_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREGS = 4
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   acc_bank_if.slave  bus
);

   localparam int               SEL_W    = $clog2(NREGS);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic             carry_q, carry_d;

   cmd_e             cmd;
   logic             cmd_exec;
   logic [WIDTH-1:0] tgt;
   logic [WIDTH-1:0] cmd_val;
   logic [WIDTH-1:0] rd_val;

   logic             start_ack;
   logic             loop_dec;
   logic [SEL_W-1:0] lock_sel;
   logic             lock_match;

   acc_loop_ctrl #(.SEL_W(SEL_W)) u_loop (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (bus.loop_start),
      .abort_i      (bus.loop_abort),
      .sel_i        (bus.sel),
      .cnt_zero_i   (bus.data_in == '0),
      .last_i       (regs_q[lock_sel] == ONE),
      .start_ack_o  (start_ack),
      .dec_o        (loop_dec),
      .lock_sel_o   (lock_sel),
      .lock_match_o (lock_match),
      .busy_o       (bus.loop_busy),
      .done_o       (bus.loop_done)
   );

   // An accepted loop_start owns this cycle's sel; a locked entry refuses commands.
   always_comb begin
      cmd      = decode_cmd(bus.clr_en, bus.write_en, bus.alu_to_ac, bus.inc_en, bus.dec_en);
      cmd_exec = (cmd != CMD_NONE) && !start_ack && !lock_match;
      tgt      = regs_q[bus.sel];
      cmd_val  = tgt;
      case (cmd)
         CMD_CLR:  cmd_val = '0;
         CMD_LOAD: cmd_val = bus.data_in;
         CMD_ALU:  cmd_val = bus.alu_out;
         CMD_INC:  cmd_val = tgt + ONE;
         CMD_DEC:  cmd_val = tgt - ONE;
         default:  cmd_val = tgt;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         if (loop_dec && (lock_sel == SEL_W'(i)))
            regs_d[i] = regs_q[i] - ONE;
         if (bus.sel == SEL_W'(i)) begin
            if (start_ack)     regs_d[i] = bus.data_in;
            else if (cmd_exec) regs_d[i] = cmd_val;
         end
      end
   end

   always_comb begin
      carry_d = carry_q;
      if (cmd_exec && (cmd == CMD_INC)) carry_d = (tgt == ALL_ONES);
      if (cmd_exec && (cmd == CMD_DEC)) carry_d = (tgt == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         carry_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
         carry_q <= carry_d;
      end
   end

   assign rd_val       = regs_q[bus.rd_sel];
   assign bus.data_out = rd_val;
   assign bus.zero     = (rd_val == '0);
   assign bus.carry    = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_acc_bank.sv
// tb_acc_bank: directed plus randomized checks of acc_bank against a cycle-indexed reference model.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_acc_bank;

   localparam int W = 16;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   acc_bank_if #(.WIDTH(W), .NREGS(N)) bus ();

   acc_bank #(.WIDTH(W), .NREGS(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // Loop modelled by edge indices: start edge k, count n; busy until edge k+n+1.
   logic [W-1:0] m_regs [N];
   bit           m_carry;
   bit           m_active;
   bit           m_done;
   int           m_k, m_n, m_ent;
   int           edge_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < N; i++) m_regs[i] = '0;
      m_carry  = 0;
      m_active = 0;
      m_done   = 0;
   endtask

   task automatic model_edge();
      logic [W-1:0] nr [N];
      bit in_count, start_taken, locked;
      int s;
      edge_cnt++;
      s = int'(bus.sel);
      nr = m_regs;
      in_count    = m_active && (edge_cnt > m_k) && (edge_cnt <= m_k + m_n);
      start_taken = !m_active && bus.loop_start;
      locked      = in_count && (s == m_ent);
      if (in_count) begin
         if (bus.loop_abort) m_active = 0;
         else nr[m_ent] = m_regs[m_ent] - 1'b1;
      end
      if (start_taken) begin
         nr[s]    = bus.data_in;
         m_active = 1;
         m_k      = edge_cnt;
         m_n      = int'(bus.data_in);
         m_ent    = s;
      end else if (!locked) begin
         if (bus.clr_en)         nr[s] = '0;
         else if (bus.write_en)  nr[s] = bus.data_in;
         else if (bus.alu_to_ac) nr[s] = bus.alu_out;
         else if (bus.inc_en) begin
            nr[s] = m_regs[s] + 1'b1;
            m_carry = (m_regs[s] == 16'hFFFF);
         end else if (bus.dec_en) begin
            nr[s] = m_regs[s] - 1'b1;
            m_carry = (m_regs[s] == 16'h0000);
         end
      end
      if (m_active && (edge_cnt == m_k + m_n + 1)) m_active = 0;
      m_done = m_active && (edge_cnt == m_k + m_n);
      m_regs = nr;
   endtask

   task automatic check_outputs();
      chk("data_out", bus.data_out, m_regs[bus.rd_sel]);
      chk("zero", bus.zero, (m_regs[bus.rd_sel] == '0));
      chk("carry", bus.carry, m_carry);
      chk("loop_busy", bus.loop_busy, m_active);
      chk("loop_done", bus.loop_done, m_done);
   endtask

   task automatic check_all();
      logic [1:0] keep;
      keep = bus.rd_sel;
      for (int r = 0; r < N; r++) begin
         bus.rd_sel = 2'(r);
         #1;
         chk("entry", bus.data_out, m_regs[r]);
      end
      bus.rd_sel = keep;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic op(input int s, input bit clr, input bit wr, input bit alu, input bit inc,
                     input bit dec, input logic [W-1:0] din, input logic [W-1:0] aout,
                     input bit ls, input bit la);
      @(negedge clk);
      bus.sel        = 2'(s);
      bus.clr_en     = clr;
      bus.write_en   = wr;
      bus.alu_to_ac  = alu;
      bus.inc_en     = inc;
      bus.dec_en     = dec;
      bus.data_in    = din;
      bus.alu_out    = aout;
      bus.loop_start = ls;
      bus.loop_abort = la;
      step();
   endtask

   task automatic idle();
      op(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
   endtask

   initial begin
      bus.sel = '0; bus.clr_en = 0; bus.write_en = 0; bus.alu_to_ac = 0;
      bus.inc_en = 0; bus.dec_en = 0; bus.data_in = '0; bus.alu_out = '0;
      bus.loop_start = 0; bus.loop_abort = 0; bus.rd_sel = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Priority
      bus.rd_sel = 2'd1;
      op(1, 0, 1, 1, 1, 0, 16'd75, 16'd56, 0, 0);
      chk("prio_wr", bus.data_out, 16'd75);
      op(1, 0, 0, 1, 1, 0, 16'd75, 16'd56, 0, 0);
      chk("prio_alu", bus.data_out, 16'd56);
      op(1, 1, 1, 0, 0, 0, 16'd99, 16'd0, 0, 0);
      chk("prio_clr", bus.data_out, 16'd0);

      // Wrap and carry
      op(1, 0, 1, 0, 0, 0, 16'hFFFF, 16'h0, 0, 0);
      op(1, 0, 0, 0, 1, 0, 16'h0, 16'h0, 0, 0);
      chk("wrap_inc", {bus.data_out, 14'd0, bus.carry, bus.zero}, {16'h0000, 14'd0, 1'b1, 1'b1});
      op(1, 0, 0, 0, 1, 0, 16'h0, 16'h0, 0, 0);
      chk("inc_nocarry", {bus.data_out, 15'd0, bus.carry}, {16'h0001, 15'd0, 1'b0});
      op(1, 0, 0, 0, 0, 1, 16'h0, 16'h0, 0, 0);
      op(1, 0, 0, 0, 0, 1, 16'h0, 16'h0, 0, 0);
      chk("wrap_dec", {bus.data_out, 15'd0, bus.carry}, {16'hFFFF, 15'd0, 1'b1});
      op(1, 0, 1, 0, 0, 0, 16'h0005, 16'h0, 0, 0);
      chk("load_keeps_carry", bus.carry, 1'b1);

      // Asynchronous reset mid-cycle
      bus.rd_sel = 2'd2;
      op(2, 0, 1, 0, 0, 0, 16'h1234, 16'h0, 0, 0);
      chk("pre_reset", bus.data_out, 16'h1234);
      idle();
      #3;
      rst_n = 1'b0;
      #1;
      m_reset();
      chk("async_rst_data", bus.data_out, 16'h0);
      chk("async_rst_carry", bus.carry, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_all();

      // Loop N=3 on entry 0 with lock
      bus.rd_sel = 2'd0;
      op(0, 0, 0, 0, 0, 0, 16'd3, 16'h0, 1, 0);
      chk("loop3_start", bus.data_out, 16'd3);
      op(0, 0, 0, 0, 1, 0, 16'h0, 16'h0, 0, 0);
      chk("loop3_locked_inc", bus.data_out, 16'd2);
      op(3, 0, 0, 0, 1, 0, 16'h0, 16'h0, 0, 0);
      chk("loop3_cnt1", bus.data_out, 16'd1);
      check_all();
      idle();
      chk("loop3_zero", bus.data_out, 16'd0);
      idle();
      idle();

      // Loop N=0, then a start while busy is ignored
      op(0, 0, 0, 0, 0, 0, 16'd0, 16'h0, 1, 0);
      chk("loop0_done", bus.loop_done, 1'b1);
      op(0, 0, 0, 0, 0, 0, 16'd7, 16'h0, 1, 0);
      chk("loop0_busy_start", bus.data_out, 16'd0);
      idle();

      // Abort after 4 decrements
      bus.rd_sel = 2'd1;
      op(1, 0, 0, 0, 0, 0, 16'd10, 16'h0, 1, 0);
      repeat (4) idle();
      op(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 1);
      chk("abort_val", {bus.data_out, 14'd0, bus.loop_busy, bus.loop_done}, {16'd6, 16'd0});
      idle();

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         bit ls;
         logic [W-1:0] din;
         ls  = ($urandom_range(0, 7) == 0);
         din = ls ? 16'($urandom_range(0, 12))
                  : (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
         bus.rd_sel = 2'($urandom_range(0, 3));
         op(int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            din, 16'($urandom), ls, ($urandom_range(0, 15) == 0));
         if ((c % 8) == 0) check_all();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
